ifetch_unit: RTL

Instruction fetch front end: owns the program counter, issues one fetch at a time to the instruction cache over the `icache_if.requester` modport, and buffers returned instructions with their PCs in a small FIFO for decode. It handles branch/exception redirects, including discarding a response that is still in flight, and never disturbs `pc_addr` while a cache lookup or refill is outstanding.

---
 rtl/ifetch_unit_if.sv | 10 +
 rtl/ifetch_unit.sv | 118 +++++++++++
 2 files changed

// File: rtl/ifetch_unit_if.sv
// Fetch request/response channel between the fetch front end and the instruction cache.
interface icache_if;
    logic [31:0] pc_addr;
    logic        pc_valid;
    logic [31:0] instruction;
    logic        instr_valid;

    modport requester (output pc_addr, output pc_valid, input instruction, input instr_valid);
    modport responder (input pc_addr, input pc_valid, output instruction, output instr_valid);
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: PC ownership, single-outstanding icache fetch,
// redirect handling and a small instruction/PC buffer toward decode.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_BOOT  | first cycle out of reset, no request
//   S_ISSUE | present fetch_pc, request when a buffer slot is free
//   S_WAIT  | one request outstanding, pc_addr frozen on req_pc
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    icache_if.requester        icache,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_pc,
    input  logic               out_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      fetch_pc;
    logic [31:0]      req_pc;
    logic             drop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [31:0]      mem_instr [FIFO_DEPTH];
    logic [31:0]      mem_pc    [FIFO_DEPTH];

    logic issue_fire;
    logic resp;
    logic push;
    logic pop;

    assign out_valid = (count != '0);
    assign out_instr = mem_instr[rd_ptr];
    assign out_pc    = mem_pc[rd_ptr];

    always_comb begin
        state_nxt       = state;
        issue_fire      = 1'b0;
        resp            = 1'b0;
        push            = 1'b0;
        icache.pc_valid = 1'b0;
        icache.pc_addr  = req_pc;
        case (state)
            S_BOOT: state_nxt = S_ISSUE;
            S_ISSUE: begin
                icache.pc_addr  = fetch_pc;
                issue_fire      = (count < FULL_COUNT) && !redirect_valid;
                icache.pc_valid = issue_fire;
                if (issue_fire) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // pc_addr stays on req_pc even across a redirect: the cache refills by it
                resp = icache.instr_valid;
                push = resp && !drop && !redirect_valid;
                if (resp) state_nxt = S_ISSUE;
            end
            default: state_nxt = S_BOOT;
        endcase
        pop = out_valid && out_ready && !redirect_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_BOOT;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            drop     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (issue_fire) req_pc <= fetch_pc;
            if (redirect_valid) fetch_pc <= redirect_pc & ~32'h3;
            else if (push)      fetch_pc <= req_pc + 32'd4;
            if (resp)                                  drop <= 1'b0;
            else if (state == S_WAIT && redirect_valid) drop <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_instr[wr_ptr] <= icache.instruction;
                mem_pc[wr_ptr]    <= req_pc;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end
endmodule
